// File: rtl/pe_pkg.sv
// Shared constants, drain FSM encoding, beat payload and lane helper for the PE accumulator buffer.
package pe_pkg;

  localparam int unsigned ARRAY_DIM  = 16;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned VEC_W      = ARRAY_DIM * ACC_W;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned LANE_IDX_W = $clog2(ARRAY_DIM);

  typedef logic [ARRAY_DIM-1:0][ACC_W-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic              clr;
    logic [ADDR_W-1:0] addr;
    lane_vec_t         data;
  } acc_beat_t;

  function automatic logic [ACC_W-1:0] lane_get(input lane_vec_t vec,
                                                input logic [LANE_IDX_W-1:0] idx);
    return vec[idx];
  endfunction

endpackage

// File: rtl/pe_acc_ram.sv
// Vector RAM for the accumulator buffer: 1R1W, registered read, returns old data on a
// same-address read/write collision. Contents are not reset.
module pe_acc_ram
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  lane_vec_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output lane_vec_t         rdata
);

  lane_vec_t mem [DEPTH];
  lane_vec_t rdata_d;
  lane_vec_t rdata_q;

  always_comb rdata_d = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pe_acc_buffer.sv
// Accumulator buffer: 2-stage read-modify-write pipe into a vector RAM plus a drain FSM that
// streams entries over valid/ready. Define ACC_BUF_RELU_EN to ReLU each out_data lane.
module pe_acc_buffer
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_enable,
  input  logic              acc_clear,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [VEC_W-1:0]  pe_acc_in,
  input  logic              drain_start,
  input  logic [CNT_W-1:0]  drain_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              drain_done,
  output logic              err_overlap
);

  drain_state_e      state_q, state_d;
  logic              c0_en_q, c0_en_d;
  acc_beat_t         c0_q, c0_d;
  logic              fw_en_q, fw_en_d;
  logic [ADDR_W-1:0] fw_addr_q, fw_addr_d;
  lane_vec_t         fw_data_q, fw_data_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              busy_q, busy_d;
  logic              drain_done_q, drain_done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] rd_addr;
  lane_vec_t         rd_data, old_vec, sum_vec, out_vec;
  logic              beat_ok;

  // Beats only land while idle and in range; out-of-range ones are silently dropped.
  assign beat_ok = acc_enable && (state_q == ST_IDLE) && (CNT_W'(acc_addr) < CNT_W'(DEPTH));

  // The RAM read returns pre-write data for last cycle's write, so take the forwarded copy.
  always_comb begin
    old_vec = rd_data;
    if (fw_en_q && (fw_addr_q == c0_q.addr)) old_vec = fw_data_q;
  end

  for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_lane
    assign sum_vec[g] = c0_q.clr ? lane_get(c0_q.data, LANE_IDX_W'(g))
                                 : lane_get(old_vec, LANE_IDX_W'(g)) + lane_get(c0_q.data, LANE_IDX_W'(g));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    c0_en_d   = beat_ok;
    c0_d.clr  = acc_clear;
    c0_d.addr = acc_addr;
    c0_d.data = pe_acc_in;
    fw_en_d   = c0_en_q;
    fw_addr_d = c0_q.addr;
    fw_data_d = sum_vec;
    rd_addr   = acc_addr;
    err_d     = err_q | (acc_enable && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          cnt_d   = drain_count;
          idx_d   = '0;
          state_d = (drain_count == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        rd_addr = '0;
        if (!c0_en_q) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        rd_addr = idx_q;
        if (out_ready) begin
          if ((CNT_W'(idx_q) + CNT_W'(1)) < cnt_q) begin
            idx_d   = idx_q + ADDR_W'(1);
            rd_addr = idx_q + ADDR_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    out_valid_d  = (state_d == ST_STREAM);
    out_addr_d   = idx_d;
    drain_done_d = (state_d == ST_DONE);
    busy_d       = c0_en_d || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      c0_en_q      <= 1'b0;
      c0_q         <= '0;
      fw_en_q      <= 1'b0;
      fw_addr_q    <= '0;
      fw_data_q    <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      c0_en_q      <= c0_en_d;
      c0_q         <= c0_d;
      fw_en_q      <= fw_en_d;
      fw_addr_q    <= fw_addr_d;
      fw_data_q    <= fw_data_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
    end
  end

  pe_acc_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (c0_en_q),
    .waddr (c0_q.addr),
    .wdata (sum_vec),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef ACC_BUF_RELU_EN
  for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_relu
    assign out_vec[g] = rd_data[g][ACC_W-1] ? '0 : rd_data[g];
  end
`else
  assign out_vec = rd_data;
`endif

  assign out_data    = out_vec;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign busy        = busy_q;
  assign drain_done  = drain_done_q;
  assign err_overlap = err_q;

endmodule

// File: tb/tb_pe_acc_buffer.sv
// Bench for pe_acc_buffer: table-driven accumulate vectors, hand-written corner sequences and
// random beats checked against an unpipelined per-entry model. Follows ACC_BUF_RELU_EN.
module tb_pe_acc_buffer;
  import pe_pkg::*;

  logic              clk = 1'b0;
  logic              rst, acc_enable, acc_clear, drain_start, out_ready;
  logic [ADDR_W-1:0] acc_addr;
  logic [VEC_W-1:0]  pe_acc_in;
  logic [CNT_W-1:0]  drain_count;
  logic              out_valid, busy, drain_done, err_overlap;
  logic [VEC_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;

  int n_checks = 0;
  int n_errors = 0;
  lane_vec_t mem_m [16];

  typedef struct {
    bit              clr;
    int              addr;
    logic [ACC_W-1:0] base, step, e0, e15;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  pe_acc_buffer dut (
    .clk(clk), .rst(rst), .acc_enable(acc_enable), .acc_clear(acc_clear), .acc_addr(acc_addr),
    .pe_acc_in(pe_acc_in), .drain_start(drain_start), .drain_count(drain_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .drain_done(drain_done), .err_overlap(err_overlap)
  );

  function automatic logic [ACC_W-1:0] exp_lane(input logic [ACC_W-1:0] v);
`ifdef ACC_BUF_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic lane_vec_t exp_vec(input lane_vec_t v);
    lane_vec_t r;
    for (int i = 0; i < 16; i++) r[i[3:0]] = exp_lane(v[i[3:0]]);
    return r;
  endfunction

  function automatic lane_vec_t splat(input logic [ACC_W-1:0] base, input logic [ACC_W-1:0] step);
    lane_vec_t r;
    for (int i = 0; i < 16; i++) r[i[3:0]] = base + step * ACC_W'(i);
    return r;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One accumulate beat; the model applies it immediately with plain per-lane arithmetic.
  task automatic beat(input bit clr, input int addr, input lane_vec_t d);
    acc_enable = 1'b1; acc_clear = clr; acc_addr = ADDR_W'(addr); pe_acc_in = d;
    @(posedge clk); #1;
    acc_enable = 1'b0; acc_clear = 1'b0;
    for (int i = 0; i < 16; i++)
      mem_m[addr[3:0]][i[3:0]] = clr ? d[i[3:0]] : mem_m[addr[3:0]][i[3:0]] + d[i[3:0]];
  endtask

  // mode 0: ready=1, 1: ready pattern 1,0,0,..., 2: random ready.
  // inject bit0: acc_enable during STREAM, bit1: drain_start during STREAM.
  task automatic do_drain(input int cnt, input int mode, input int inject, input string tag,
                          output lane_vec_t last);
    int got, cyc, phase;
    bit fin, injected, accepted;
    got = 0; cyc = 0; phase = 0; fin = 0; injected = 0; last = '0;
    drain_count = CNT_W'(cnt); drain_start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drain_start = 1'b0;
    if (cnt == 0) begin
      check_bit({tag, " zero-count done"}, drain_done, 1'b1);
      check_bit({tag, " zero-count valid"}, out_valid, 1'b0);
      @(posedge clk); #1;
      check_bit({tag, " zero-count done drop"}, drain_done, 1'b0);
      check_bit({tag, " zero-count valid after"}, out_valid, 1'b0);
      return;
    end
    while (!fin) begin
      if (got == cnt) begin
        check_bit({tag, " done pulse"}, drain_done, 1'b1);
        check_bit({tag, " valid after last"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check_bit({tag, " done drop"}, drain_done, 1'b0);
        check_bit({tag, " idle busy"}, busy, 1'b0);
        fin = 1;
      end else if (cyc >= 400) begin
        n_checks++; n_errors++;
        $display("FAIL %s timeout: got %0d of %0d beats", tag, got, cnt);
        fin = 1;
      end else begin
        out_ready = 1'b0;
        if (out_valid) begin
          n_checks++;
          if (out_addr !== ADDR_W'(got) || out_data !== exp_vec(mem_m[got[3:0]]) || drain_done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s beat%0d: addr %0d data %0h done %b, required addr %0d data %0h done 0",
                     tag, got, out_addr, out_data, drain_done, got, exp_vec(mem_m[got[3:0]]));
          end
          last = out_data;
          case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (phase % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
          endcase
          phase++;
          if (!injected && inject[0]) begin
            acc_enable = 1'b1; acc_clear = 1'b1; acc_addr = '0; pe_acc_in = splat(32'hDEAD, 32'd0);
          end
          if (!injected && inject[1]) begin
            drain_start = 1'b1; drain_count = CNT_W'(1);
          end
          injected = 1;
        end
        accepted = out_valid && out_ready;
        @(posedge clk); #1;
        cyc++;
        acc_enable = 1'b0; acc_clear = 1'b0; drain_start = 1'b0;
        if (accepted) got++;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lane_vec_t last;
    bit seen;
    tv[0] = '{1'b1, 5, 32'd3,          32'd0,    32'd3,          32'd3};
    tv[1] = '{1'b0, 5, 32'd4,          32'd0,    32'd7,          32'd7};
    tv[2] = '{1'b1, 1, 32'd10,         32'd1,    32'd10,         32'd25};
    tv[3] = '{1'b0, 1, 32'hFFFFFFFF,   32'd0,    32'd9,          32'd24};
    tv[4] = '{1'b1, 3, 32'h7FFFFFFF,   32'd0,    32'h7FFFFFFF,   32'h7FFFFFFF};
    tv[5] = '{1'b0, 3, 32'd1,          32'd0,    32'h80000000,   32'h80000000};
    tv[6] = '{1'b1, 0, 32'h80000000,   32'h10,   32'h80000000,   32'h800000F0};
    tv[7] = '{1'b0, 0, 32'h80000000,   32'd0,    32'h00000000,   32'h000000F0};

    rst = 1'b1; acc_enable = 1'b0; acc_clear = 1'b0; acc_addr = '0; pe_acc_in = '0;
    drain_start = 1'b0; drain_count = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset drain_done", drain_done, 1'b0);
    check_bit("reset err_overlap", err_overlap, 1'b0);
    check_vec("reset out_addr", VEC_W'(out_addr), '0);
    check_vec("reset out_data", out_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // RAM is not reset: give every entry the bench will drain a known value.
    for (int a = 0; a < 16; a++) beat(1'b1, a, '0);
    check_bit("busy after beat", busy, 1'b1);
    @(posedge clk); #1;
    check_bit("busy pipe empty", busy, 1'b0);

    for (int t = 0; t < 8; t++) begin
      beat(tv[t[2:0]].clr, tv[t[2:0]].addr, splat(tv[t[2:0]].base, tv[t[2:0]].step));
      do_drain(tv[t[2:0]].addr + 1, 0, 0, $sformatf("vec%0d", t), last);
      check_vec($sformatf("vec%0d lane0", t), VEC_W'(last[0]), VEC_W'(exp_lane(tv[t[2:0]].e0)));
      check_vec($sformatf("vec%0d lane15", t), VEC_W'(last[15]), VEC_W'(exp_lane(tv[t[2:0]].e15)));
    end

    // Back-to-back hits on one address.
    beat(1'b1, 2, splat(32'd1, 32'd0));
    repeat (3) beat(1'b0, 2, splat(32'd1, 32'd0));
    do_drain(3, 0, 0, "b2b", last);
    check_vec("b2b entry2", last, exp_vec(splat(32'd4, 32'd0)));

    // Stalling sink.
    for (int a = 0; a < 4; a++) beat(1'b1, a, splat(ACC_W'(100 * a), ACC_W'(a)));
    do_drain(4, 1, 0, "stall", last);
    check_vec("stall entry3", last, exp_vec(splat(32'd300, 32'd3)));

    // Random beats, random gaps, random ready.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 80; n++) begin
        lane_vec_t d;
        for (int i = 0; i < 16; i++) d[i[3:0]] = $urandom();
        beat($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), d);
        if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      end
      do_drain(8, 2, 0, $sformatf("rand%0d", r), last);
    end

    // Overlap: beat and drain_start during STREAM are both dropped.
    check_bit("err_overlap clear before", err_overlap, 1'b0);
    do_drain(4, 0, 3, "overlap", last);
    check_bit("err_overlap set", err_overlap, 1'b1);
    do_drain(4, 0, 0, "post-overlap", last);
    do_drain(0, 0, 0, "zero", last);
    check_bit("err_overlap sticky", err_overlap, 1'b1);

    // Reset in the middle of STREAM.
    drain_count = CNT_W'(8); drain_start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drain_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    check_bit("pre-reset streaming", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("mid-stream rst out_valid", out_valid, 1'b0);
    check_bit("mid-stream rst busy", busy, 1'b0);
    check_bit("mid-stream rst drain_done", drain_done, 1'b0);
    check_bit("mid-stream rst err_overlap", err_overlap, 1'b0);
    @(posedge clk); #1;
    check_bit("rst held drain_done", drain_done, 1'b0);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) beat(1'b1, a, splat(ACC_W'(a + 1), 32'd2));
    do_drain(8, 0, 0, "post-reset", last);
    check_vec("post-reset entry7", last, exp_vec(splat(32'd8, 32'd2)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
